// File: rtl/ecdsa_job_sequencer_if.sv
// Job, engine and result signals of the ECDSA job sequencer, bundled as one interface.
// Latency: none, wiring only.
// Backpressure: job_valid/job_ready and res_valid/res_ready handshakes; engines use start/done.
interface ecdsa_job_sequencer_if #(
    parameter int MSG_W = 96,
    parameter int KEY_W = 256,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
);
    // job intake
    logic                       job_valid;
    logic                       job_ready;
    logic [1:0]                 job_mode;
    logic [TAG_W-1:0]           job_tag;
    logic [MSG_W-1:0]           job_msg;
    logic [KEY_W-1:0]           job_key;
    logic [2*KEY_W-1:0]         job_sig;
    // public-key engine
    logic                       gen_start;
    logic [KEY_W-1:0]           gen_key;
    logic                       gen_done;
    logic [2*KEY_W-1:0]         gen_point;
    // sign engine
    logic                       sign_start;
    logic [MSG_W-1:0]           sign_msg;
    logic [KEY_W-1:0]           sign_key;
    logic                       sign_done;
    logic [2*KEY_W-1:0]         sign_sig;
    // verify engine
    logic                       ver_start;
    logic [MSG_W-1:0]           ver_msg;
    logic [2*KEY_W-1:0]         ver_sig;
    logic [2*KEY_W-1:0]         ver_pub;
    logic                       ver_done;
    logic                       ver_invalid;
    // result FIFO head
    logic                       res_valid;
    logic                       res_ready;
    logic [TAG_W-1:0]           res_tag;
    logic [1:0]                 res_status;
    logic [2*KEY_W-1:0]         res_sig;
    logic [$clog2(DEPTH+1)-1:0] res_count;
    logic                       busy;

    // Environment side: offers jobs, models the engines, drains results.
    modport master (
        output job_valid, job_mode, job_tag, job_msg, job_key, job_sig,
        output gen_done, gen_point, sign_done, sign_sig, ver_done, ver_invalid, res_ready,
        input  job_ready, gen_start, gen_key, sign_start, sign_msg, sign_key,
        input  ver_start, ver_msg, ver_sig, ver_pub,
        input  res_valid, res_tag, res_status, res_sig, res_count, busy
    );

    // Sequencer side.
    modport slave (
        input  job_valid, job_mode, job_tag, job_msg, job_key, job_sig,
        input  gen_done, gen_point, sign_done, sign_sig, ver_done, ver_invalid, res_ready,
        output job_ready, gen_start, gen_key, sign_start, sign_msg, sign_key,
        output ver_start, ver_msg, ver_sig, ver_pub,
        output res_valid, res_tag, res_status, res_sig, res_count, busy
    );
endinterface

// File: rtl/ecdsa_job_sequencer.sv
// Sequences one ECDSA job (sign / verify / sign+verify) over external engines into a result FIFO.
// Latency: bad mode gives res_valid 3 cycles after accept; completion gives res_valid 2 cycles after the last done.
// Backpressure: job_ready only in IDLE with a free FIFO slot; results held in the FIFO until res_ready.
module ecdsa_job_sequencer #(
    parameter int MSG_W   = 96,
    parameter int KEY_W   = 256,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            reset_n,
    ecdsa_job_sequencer_if.slave bus
);
    localparam int SIG_W = 2 * KEY_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_VER   = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_BAD   = 2'b11;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_INVALID = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BADMODE = 2'b11;

    typedef struct packed {
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
        logic [MSG_W-1:0] msg;
        logic [KEY_W-1:0] key;
        logic [SIG_W-1:0] sig;
    } job_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       status;
        logic [SIG_W-1:0] sig;
    } res_t;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT1, VSTART, WAIT2, PUSH} state_t;

    state_t           state_q, state_d;
    job_t             job_q;
    logic             gen_flag_q, sign_flag_q;
    logic [SIG_W-1:0] point_q, ssig_q;
    logic [CNT_W-1:0] tmo_q;
    logic [1:0]       pend_status_q;
    logic [SIG_W-1:0] pend_sig_q;

    res_t             mem [DEPTH];
    res_t             head;
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [OCC_W-1:0] count_q;

    logic             job_ready, accept, need_gen, need_sign, gen_ok, sign_ok, stage1_done, tmo_hit;
    logic             push, pop, res_valid;
    logic             gen_start, sign_start, ver_start;
    logic [SIG_W-1:0] ver_sig_sel;

    assign job_ready   = (state_q == IDLE) && (count_q < OCC_W'(DEPTH));
    assign accept      = bus.job_valid && job_ready;
    assign need_gen    = (job_q.mode == MODE_VER) || (job_q.mode == MODE_BOTH);
    assign need_sign   = (job_q.mode == MODE_SIGN) || (job_q.mode == MODE_BOTH);
    // A done on the current cycle counts, so completion costs no extra cycle.
    assign gen_ok      = !need_gen || gen_flag_q || bus.gen_done;
    assign sign_ok     = !need_sign || sign_flag_q || bus.sign_done;
    assign stage1_done = gen_ok && sign_ok;
    assign tmo_hit     = (tmo_q == CNT_W'(TIMEOUT - 1));
    assign ver_sig_sel = (job_q.mode == MODE_BOTH) ? ssig_q : job_q.sig;
    assign push        = (state_q == PUSH);
    assign res_valid   = (count_q != '0);
    assign pop         = res_valid && bus.res_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: completion is checked before the timeout so a last-cycle done wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LAUNCH;
            LAUNCH:  state_d = (job_q.mode == MODE_BAD) ? PUSH : WAIT1;
            WAIT1: begin
                if (stage1_done)  state_d = (job_q.mode == MODE_SIGN) ? PUSH : VSTART;
                else if (tmo_hit) state_d = PUSH;
            end
            VSTART:  state_d = WAIT2;
            WAIT2:   if (bus.ver_done || tmo_hit) state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Engine start pulses, one cycle each, decoded from state and latched mode.
    always_comb begin
        gen_start  = 1'b0;
        sign_start = 1'b0;
        ver_start  = 1'b0;
        case (state_q)
            LAUNCH: begin
                gen_start  = need_gen;
                sign_start = need_sign;
            end
            VSTART:  ver_start = 1'b1;
            default: ;
        endcase
    end

    // Job latch, engine result capture, timeout counter and pending result status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_q         <= '0;
            gen_flag_q    <= 1'b0;
            sign_flag_q   <= 1'b0;
            point_q       <= '0;
            ssig_q        <= '0;
            tmo_q         <= '0;
            pend_status_q <= '0;
            pend_sig_q    <= '0;
        end else begin
            if (accept) begin
                job_q.mode <= bus.job_mode;
                job_q.tag  <= bus.job_tag;
                job_q.msg  <= bus.job_msg;
                job_q.key  <= bus.job_key;
                job_q.sig  <= bus.job_sig;
            end
            case (state_q)
                LAUNCH: begin
                    // Dones during the start cycle are deliberately not looked at.
                    tmo_q         <= '0;
                    gen_flag_q    <= 1'b0;
                    sign_flag_q   <= 1'b0;
                    pend_status_q <= ST_BADMODE;
                    pend_sig_q    <= '0;
                end
                WAIT1: begin
                    tmo_q <= tmo_q + CNT_W'(1);
                    if (bus.gen_done && !gen_flag_q) begin
                        gen_flag_q <= 1'b1;
                        point_q    <= bus.gen_point;
                    end
                    if (bus.sign_done && !sign_flag_q) begin
                        sign_flag_q <= 1'b1;
                        ssig_q      <= bus.sign_sig;
                    end
                    if (stage1_done) begin
                        pend_status_q <= ST_OK;
                        pend_sig_q    <= sign_flag_q ? ssig_q : bus.sign_sig;
                    end else if (tmo_hit) begin
                        pend_status_q <= ST_TIMEOUT;
                        pend_sig_q    <= '0;
                    end
                end
                VSTART: tmo_q <= '0;
                WAIT2: begin
                    tmo_q <= tmo_q + CNT_W'(1);
                    if (bus.ver_done) begin
                        pend_status_q <= bus.ver_invalid ? ST_INVALID : ST_OK;
                        pend_sig_q    <= ver_sig_sel;
                    end else if (tmo_hit) begin
                        pend_status_q <= ST_TIMEOUT;
                        pend_sig_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= '{tag: job_q.tag, status: pend_status_q, sig: pend_sig_q};
    end

    // FIFO pointers and occupancy; pointers wrap explicitly so DEPTH may be any value >= 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            if (pop)  rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign head           = mem[rd_q];
    assign bus.job_ready  = job_ready;
    assign bus.gen_start  = gen_start;
    assign bus.sign_start = sign_start;
    assign bus.ver_start  = ver_start;
    assign bus.gen_key    = job_q.key;
    assign bus.sign_msg   = job_q.msg;
    assign bus.sign_key   = job_q.key;
    assign bus.ver_msg    = job_q.msg;
    assign bus.ver_sig    = ver_sig_sel;
    assign bus.ver_pub    = point_q;
    assign bus.res_valid  = res_valid;
    assign bus.res_tag    = res_valid ? head.tag    : '0;
    assign bus.res_status = res_valid ? head.status : '0;
    assign bus.res_sig    = res_valid ? head.sig    : '0;
    assign bus.res_count  = count_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ecdsa_job_sequencer.sv
// Directed bench for ecdsa_job_sequencer with a result scoreboard.
// Latency: stimulus drives engines cycle-exactly relative to LAUNCH.
// Backpressure: res_ready is held low in the fill and reset scenarios.
module tb_ecdsa_job_sequencer;
    localparam int MSG_W   = 96;
    localparam int KEY_W   = 256;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int SW      = 2 * KEY_W;
    localparam int CW      = TAG_W + 2 + SW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_gen = 0, n_sign = 0, n_ver = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_e;

    ecdsa_job_sequencer_if #(.MSG_W(MSG_W), .KEY_W(KEY_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus();

    ecdsa_job_sequencer #(
        .MSG_W(MSG_W), .KEY_W(KEY_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chks(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and start-pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none",
                         {bus.res_tag, bus.res_status, bus.res_sig});
            end else begin
                exp_e = exp_q.pop_front();
                chkw("result", {bus.res_tag, bus.res_status, bus.res_sig}, exp_e);
            end
        end
        if (bus.gen_start)  n_gen++;
        if (bus.sign_start) n_sign++;
        if (bus.ver_start)  n_ver++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a job and return in its LAUNCH cycle.
    task automatic offer(input logic [1:0] mode, input logic [TAG_W-1:0] tag, input logic [SW-1:0] sig);
        int w = 0;
        bus.job_valid = 1'b1;
        bus.job_mode  = mode;
        bus.job_tag   = tag;
        bus.job_msg   = 96'h0123_4567_89AB_CDEF_0011_2233;
        bus.job_key   = 256'hC0FFEE;
        bus.job_sig   = sig;
        while (!bus.job_ready && w < 50) begin
            tick();
            w++;
        end
        chkn("accept_ready", int'(bus.job_ready), 1);
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((bus.res_count != 0 || bus.busy) && w < 100) begin
            tick();
            w++;
        end
        chkn("drain_done", int'(bus.res_count != 0 || bus.busy), 0);
    endtask

    initial begin
        logic [SW-1:0] s1, s2, p2, j3, p3, s5, j6;
        int g0, s0, v0;
        s1 = {256'hA1A1, 256'hB1B1};
        s2 = {256'hA2A2, 256'hB2B2};
        p2 = {256'hD2D2, 256'hE2E2};
        j3 = {256'hA3A3, 256'hB3B3};
        p3 = {256'hD3D3, 256'hE3E3};
        s5 = {256'hA5A5, 256'hB5B5};
        j6 = {256'hA6A6, 256'hB6B6};
        bus.job_valid = 1'b0; bus.job_mode = '0; bus.job_tag = '0; bus.job_msg = '0;
        bus.job_key = '0; bus.job_sig = '0;
        bus.gen_done = 1'b0; bus.gen_point = '0; bus.sign_done = 1'b0; bus.sign_sig = '0;
        bus.ver_done = 1'b0; bus.ver_invalid = 1'b0; bus.res_ready = 1'b1;

        // reset state
        tick(2);
        chkn("rst_res_valid", int'(bus.res_valid), 0);
        chkn("rst_res_count", int'(bus.res_count), 0);
        chkn("rst_busy", int'(bus.busy), 0);
        chkn("rst_starts", int'({bus.gen_start, bus.sign_start, bus.ver_start}), 0);
        chkw("rst_head", {bus.res_tag, bus.res_status, bus.res_sig}, '0);
        reset_n = 1'b1;
        tick();

        // mode 00, sign_done 10 cycles after sign_start
        g0 = n_gen; s0 = n_sign; v0 = n_ver;
        offer(2'b00, 4'd3, '0);
        exp_q.push_back({4'd3, 2'b00, s1});
        chkn("t1_launch_sign_start", int'(bus.sign_start), 1);
        tick();
        chkn("t1_sign_pulse_width", int'(bus.sign_start), 0);
        tick(9);
        bus.sign_done = 1'b1; bus.sign_sig = s1;
        tick();
        bus.sign_done = 1'b0;
        chkn("t1_valid_d1", int'(bus.res_valid), 0);
        tick();
        chkn("t1_valid_d2", int'(bus.res_valid), 1);
        chkn("t1_count_d2", int'(bus.res_count), 1);
        drain();
        chkn("t1_sign_starts", n_sign - s0, 1);
        chkn("t1_gen_starts", n_gen - g0, 0);
        chkn("t1_ver_starts", n_ver - v0, 0);

        // mode 10, gen_done at +5, sign_done at +9, verify reports invalid
        v0 = n_ver;
        offer(2'b10, 4'd5, '0);
        exp_q.push_back({4'd5, 2'b01, s2});
        chkn("t2_both_start", int'({bus.gen_start, bus.sign_start}), 3);
        tick(5);
        bus.gen_done = 1'b1; bus.gen_point = p2;
        tick();
        bus.gen_done = 1'b0;
        tick(3);
        bus.sign_done = 1'b1; bus.sign_sig = s2;
        chkn("t2_no_early_ver", int'(bus.ver_start), 0);
        tick();
        bus.sign_done = 1'b0;
        chkn("t2_ver_start", int'(bus.ver_start), 1);
        chks("t2_ver_pub", bus.ver_pub, p2);
        chks("t2_ver_sig", bus.ver_sig, s2);
        tick();
        bus.ver_done = 1'b1; bus.ver_invalid = 1'b1;
        tick();
        bus.ver_done = 1'b0; bus.ver_invalid = 1'b0;
        drain();
        chkn("t2_ver_starts", n_ver - v0, 1);

        // mode 01 with caller signature, valid
        s0 = n_sign;
        offer(2'b01, 4'd6, j3);
        exp_q.push_back({4'd6, 2'b00, j3});
        chkn("t3_gen_only", int'({bus.gen_start, bus.sign_start}), 2);
        tick(3);
        bus.gen_done = 1'b1; bus.gen_point = p3;
        tick();
        bus.gen_done = 1'b0;
        chkn("t3_ver_start", int'(bus.ver_start), 1);
        chks("t3_ver_sig", bus.ver_sig, j3);
        chks("t3_ver_pub", bus.ver_pub, p3);
        tick();
        bus.ver_done = 1'b1;
        tick();
        bus.ver_done = 1'b0;
        drain();
        chkn("t3_sign_starts", n_sign - s0, 0);

        // mode 11: no starts, result at accept+3
        offer(2'b11, 4'd7, '0);
        exp_q.push_back({4'd7, 2'b11, {SW{1'b0}}});
        chkn("t4_no_starts", int'({bus.gen_start, bus.sign_start, bus.ver_start}), 0);
        tick();
        chkn("t4_valid_k2", int'(bus.res_valid), 0);
        tick();
        chkn("t4_valid_k3", int'(bus.res_valid), 1);
        drain();

        // fill FIFO with res_ready low, fifth job must wait for a pop
        bus.res_ready = 1'b0;
        for (int t = 8; t < 8 + DEPTH; t++) begin
            exp_q.push_back({TAG_W'(t), 2'b11, {SW{1'b0}}});
            offer(2'b11, TAG_W'(t), '0);
        end
        tick(2);
        chkn("t5_count_full", int'(bus.res_count), DEPTH);
        bus.job_valid = 1'b1; bus.job_mode = 2'b11; bus.job_tag = 4'd12;
        tick(2);
        chkn("t5_ready_low", int'(bus.job_ready), 0);
        chkn("t5_not_accepted", int'(bus.busy), 0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chkn("t5_count_after_pop", int'(bus.res_count), DEPTH - 1);
        chkn("t5_ready_again", int'(bus.job_ready), 1);
        exp_q.push_back({4'd12, 2'b11, {SW{1'b0}}});
        tick();
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b1;
        drain();

        // sign engine silent: timeout after 16 wait cycles
        offer(2'b00, 4'd9, '0);
        exp_q.push_back({4'd9, 2'b10, {SW{1'b0}}});
        tick(17);
        chkn("t6_valid_l17", int'(bus.res_valid), 0);
        chkn("t6_busy_l17", int'(bus.busy), 1);
        tick();
        chkn("t6_valid_l18", int'(bus.res_valid), 1);
        drain();

        // done on the 16th wait cycle beats the timeout
        offer(2'b00, 4'd10, '0);
        exp_q.push_back({4'd10, 2'b00, s5});
        tick(16);
        bus.sign_done = 1'b1; bus.sign_sig = s5;
        tick();
        bus.sign_done = 1'b0;
        chkn("t7_valid_l17", int'(bus.res_valid), 0);
        tick();
        chkn("t7_valid_l18", int'(bus.res_valid), 1);
        drain();

        // reset during WAIT2 with two entries queued
        bus.res_ready = 1'b0;
        offer(2'b11, 4'd1, '0);
        offer(2'b11, 4'd2, '0);
        tick(2);
        chkn("t8_count_two", int'(bus.res_count), 2);
        offer(2'b01, 4'd4, j6);
        tick(2);
        bus.gen_done = 1'b1; bus.gen_point = p3;
        tick();
        bus.gen_done = 1'b0;
        tick(3);
        chkn("t8_busy_wait2", int'(bus.busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chkn("t8_rst_valid", int'(bus.res_valid), 0);
        chkn("t8_rst_count", int'(bus.res_count), 0);
        chkn("t8_rst_busy", int'(bus.busy), 0);
        chks("t8_rst_ver_sig", bus.ver_sig, '0);
        chkw("t8_rst_head", {bus.res_tag, bus.res_status, bus.res_sig}, '0);
        tick();
        reset_n = 1'b1;
        bus.ver_done = 1'b1;
        tick();
        bus.ver_done = 1'b0;
        tick(3);
        chkn("t8_late_done_count", int'(bus.res_count), 0);
        chkn("t8_late_done_busy", int'(bus.busy), 0);

        chkn("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
